// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication and load extract / extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic                  is_store,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halfwords fall back to the lane picked by addr[1] alone.
  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: wdata = store_data;
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit driving a req/gnt/rvalid data bus.
// Optional LSU_MISALIGN_CHECK_EN: flag misaligned H/W accesses and suppress them.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_rs2_data,
  input  logic [2:0]            mem_funct3,
  input  logic                  mem_MemRead,
  input  logic                  mem_MemWrite,
  input  logic                  mem_flush,
  input  logic                  wb_ready,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  output logic [BE_WIDTH-1:0]   dbus_be,
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic [DATA_WIDTH-1:0] mem_load_data,
  output logic                  mem_stall,
  output logic                  mem_misaligned
);

  lsu_state_e state_q, state_d;
  logic discard_q, discard_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_out, fmt_data, wdata;
  logic [ADDR_WIDTH-1:0] addr_q, cur_addr;
  logic [DATA_WIDTH-1:0] rs2_q, cur_rs2;
  logic [2:0] funct3_q, cur_funct3;
  logic store_q, cur_store;
  logic [BE_WIDTH-1:0] be;
  logic access, is_store, misaligned, issue, in_idle, req, stall;

  assign access   = mem_MemRead | mem_MemWrite;
  assign is_store = mem_MemWrite & ~mem_MemRead;
  assign in_idle  = (state_q == IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = access & in_idle & is_misaligned(mem_funct3, mem_alu_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign issue = access & ~mem_flush & ~misaligned;

  // Once issued, the request is replayed from a private copy so it cannot drift.
  assign cur_addr   = in_idle ? mem_alu_result : addr_q;
  assign cur_rs2    = in_idle ? mem_rs2_data   : rs2_q;
  assign cur_funct3 = in_idle ? mem_funct3     : funct3_q;
  assign cur_store  = in_idle ? is_store       : store_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH), .BE_WIDTH(BE_WIDTH)) u_align (
    .addr_lo    (cur_addr[1:0]),
    .funct3     (cur_funct3),
    .is_store   (cur_store),
    .store_data (cur_rs2),
    .rdata      (dbus_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
    end else if (in_idle && issue) begin
      addr_q   <= mem_alu_result;
      rs2_q    <= mem_rs2_data;
      funct3_q <= mem_funct3;
      store_q  <= is_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (state_q == RESP && dbus_rvalid) load_data_q <= load_out;
    end
  end

  // A flushed transaction still completes on the bus; only its result is dropped.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req       = 1'b0;
    stall     = 1'b0;
    load_out  = '0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (issue) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_d = dbus_gnt ? RESP : REQ;
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem_flush) discard_d = 1'b1;
        if (dbus_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_flush) discard_d = 1'b1;
        if (dbus_rvalid) begin
          load_out  = (discard_q | mem_flush) ? '0 : fmt_data;
          discard_d = 1'b0;
          state_d   = (discard_q | mem_flush | wb_ready) ? IDLE : DONE;
        end else begin
          stall = 1'b1;
        end
      end
      DONE: begin
        load_out = load_data_q;
        if (wb_ready || mem_flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbus_req       = req;
  assign dbus_we        = req & cur_store;
  assign dbus_addr      = req ? {cur_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dbus_wdata     = req ? wdata : '0;
  assign dbus_be        = req ? be : '0;
  assign mem_load_data  = load_out;
  assign mem_stall      = stall;
  assign mem_misaligned = misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: vector table plus multi-cycle corner sequences.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_alu_result, mem_rs2_data, dbus_addr, dbus_wdata, dbus_rdata, mem_load_data;
  logic [2:0]  mem_funct3;
  logic        mem_MemRead, mem_MemWrite, mem_flush, wb_ready;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, mem_stall, mem_misaligned;
  logic [3:0]  dbus_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        wr;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_funct3(mem_funct3),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_flush(mem_flush),
    .wb_ready(wb_ready), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .mem_load_data(mem_load_data), .mem_stall(mem_stall),
    .mem_misaligned(mem_misaligned)
  );

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                              input logic wr, input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_load);
    vec_t v;
    v.addr = addr; v.rs2 = rs2; v.f3 = f3; v.wr = wr; v.rdata = rdata;
    v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic popCheck(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got=%h want=<scoreboard empty>", name, mem_load_data);
    end else begin
      checkOutput(name, mem_load_data, exp_q.pop_front());
    end
  endtask

  task automatic idleInputs();
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_flush = 1'b0;
    mem_alu_result = '0; mem_rs2_data = '0; mem_funct3 = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0; wb_ready = 1'b1;
  endtask

  task automatic driveAccess(input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                             input logic wr);
    mem_alu_result = addr; mem_rs2_data = rs2; mem_funct3 = f3;
    mem_MemRead = ~wr; mem_MemWrite = wr;
  endtask

  // Zero-wait transaction: grant with the request, response the following cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    driveAccess(v.addr, v.rs2, v.f3, v.wr);
    dbus_gnt = 1'b1; wb_ready = 1'b1;
    if (!v.wr) exp_q.push_back(v.exp_load);
    #1;
    checkOutput($sformatf("v%0d_req", idx), dbus_req, 1);
    checkOutput($sformatf("v%0d_we", idx), dbus_we, v.wr);
    checkOutput($sformatf("v%0d_addr", idx), dbus_addr, v.exp_addr);
    checkOutput($sformatf("v%0d_be", idx), dbus_be, v.exp_be);
    if (v.wr) checkOutput($sformatf("v%0d_wdata", idx), dbus_wdata, v.exp_wdata);
    checkOutput($sformatf("v%0d_stall", idx), mem_stall, 1);
    checkOutput($sformatf("v%0d_misal", idx), mem_misaligned, 0);
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = v.rdata;
    #1;
    checkOutput($sformatf("v%0d_resp_req", idx), dbus_req, 0);
    checkOutput($sformatf("v%0d_resp_stall", idx), mem_stall, 0);
    if (!v.wr) popCheck($sformatf("v%0d_load", idx));
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput($sformatf("v%0d_idle_req", idx), dbus_req, 0);
    checkOutput($sformatf("v%0d_idle_load", idx), mem_load_data, 0);
  endtask

  initial begin
    vecs.push_back(mk(32'h100, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF));
    vecs.push_back(mk(32'h103, 32'h0, 3'b000, 1'b0, 32'h80FF0000, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(32'h103, 32'h0, 3'b100, 1'b0, 32'h80FF0000, 32'h100, 4'hF, 32'h0, 32'h00000080));
    vecs.push_back(mk(32'h102, 32'h0, 3'b101, 1'b0, 32'h80FF0000, 32'h100, 4'hF, 32'h0, 32'h000080FF));
    vecs.push_back(mk(32'h102, 32'h0, 3'b001, 1'b0, 32'h80FF0000, 32'h100, 4'hF, 32'h0, 32'hFFFF80FF));
    vecs.push_back(mk(32'h101, 32'h0, 3'b000, 1'b0, 32'h00007F00, 32'h100, 4'hF, 32'h0, 32'h0000007F));
    vecs.push_back(mk(32'h100, 32'h0, 3'b001, 1'b0, 32'h12348001, 32'h100, 4'hF, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(32'h204, 32'hCAFEF00D, 3'b010, 1'b1, 32'h0, 32'h204, 4'hF, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(32'h206, 32'h1234ABCD, 3'b001, 1'b1, 32'h0, 32'h204, 4'hC, 32'hABCDABCD, 32'h0));
    vecs.push_back(mk(32'h203, 32'h00000055, 3'b000, 1'b1, 32'h0, 32'h200, 4'h8, 32'h55555555, 32'h0));
`ifndef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(32'h102, 32'h0, 3'b010, 1'b0, 32'h11223344, 32'h100, 4'hF, 32'h0, 32'h11223344));
    vecs.push_back(mk(32'h103, 32'h0, 3'b001, 1'b0, 32'hBEEF0000, 32'h100, 4'hF, 32'h0, 32'hFFFFBEEF));
    vecs.push_back(mk(32'h203, 32'h0000BEEF, 3'b001, 1'b1, 32'h0, 32'h200, 4'hC, 32'hBEEFBEEF, 32'h0));
`endif

    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", dbus_req, 0);
    checkOutput("rst_stall", mem_stall, 0);
    checkOutput("rst_load", mem_load_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_req", dbus_req, 0);
    checkOutput("idle_addr", dbus_addr, 0);
    checkOutput("idle_be", dbus_be, 0);
    checkOutput("idle_misal", mem_misaligned, 0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    $display("[TB] SB with grant delayed 3 cycles");
    @(negedge clk);
    driveAccess(32'h101, 32'h000000AB, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      dbus_gnt = (i == 3);
      #1;
      checkOutput($sformatf("sb_req%0d", i), dbus_req, 1);
      checkOutput($sformatf("sb_we%0d", i), dbus_we, 1);
      checkOutput($sformatf("sb_addr%0d", i), dbus_addr, 32'h100);
      checkOutput($sformatf("sb_be%0d", i), dbus_be, 4'b0010);
      checkOutput($sformatf("sb_wdata%0d", i), dbus_wdata, 32'hABABABAB);
      checkOutput($sformatf("sb_stall%0d", i), mem_stall, 1);
      @(negedge clk);
    end
    dbus_gnt = 1'b0;
    #1;
    checkOutput("sb_wait_req", dbus_req, 0);
    checkOutput("sb_wait_stall", mem_stall, 1);
    @(negedge clk);
    dbus_rvalid = 1'b1;
    #1;
    checkOutput("sb_ack_stall", mem_stall, 0);
    @(negedge clk);
    idleInputs();

    $display("[TB] load held by wb_ready=0");
    driveAccess(32'h100, 32'h0, 3'b010, 1'b0);
    dbus_gnt = 1'b1; wb_ready = 1'b0;
    exp_q.push_back(32'hA5A51234);
    #1;
    checkOutput("hold_req", dbus_req, 1);
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hA5A51234;
    #1;
    popCheck("hold_load");
    checkOutput("hold_rv_stall", mem_stall, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dbus_rvalid = 1'b0; dbus_rdata = 32'h0BAD0BAD; wb_ready = (i == 1);
      #1;
      checkOutput($sformatf("done_req%0d", i), dbus_req, 0);
      checkOutput($sformatf("done_stall%0d", i), mem_stall, 0);
      checkOutput($sformatf("done_load%0d", i), mem_load_data, 32'hA5A51234);
    end
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("done_exit_req", dbus_req, 0);
    checkOutput("done_exit_load", mem_load_data, 0);

    $display("[TB] flush while waiting for grant");
    @(negedge clk);
    driveAccess(32'h100, 32'h0, 3'b010, 1'b0);
    exp_q.push_back(32'h0);
    #1;
    checkOutput("fl_req0", dbus_req, 1);
    @(negedge clk);
    mem_flush = 1'b1;
    #1;
    checkOutput("fl_req1", dbus_req, 1);
    checkOutput("fl_stall1", mem_stall, 1);
    @(negedge clk);
    mem_flush = 1'b0; dbus_gnt = 1'b1;
    #1;
    checkOutput("fl_req2", dbus_req, 1);
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    #1;
    popCheck("fl_load");
    checkOutput("fl_rv_req", dbus_req, 0);
    checkOutput("fl_rv_stall", mem_stall, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("fl_after_req", dbus_req, 0);
    checkOutput("fl_after_load", mem_load_data, 0);

    $display("[TB] flush in IDLE");
    @(negedge clk);
    driveAccess(32'h100, 32'h0, 3'b010, 1'b0);
    mem_flush = 1'b1;
    #1;
    checkOutput("fli_req", dbus_req, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("fli_after_req", dbus_req, 0);
    checkOutput("fli_after_stall", mem_stall, 0);

    $display("[TB] reset mid-transaction");
    @(negedge clk);
    driveAccess(32'h100, 32'h0, 3'b010, 1'b0);
    dbus_gnt = 1'b1;
    #1;
    checkOutput("rmt_req", dbus_req, 1);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("rmt_resp_stall", mem_stall, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmt_rst_stall", mem_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rmt_after_req", dbus_req, 0);
    checkOutput("rmt_after_stall", mem_stall, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    $display("[TB] misaligned LW suppressed");
    @(negedge clk);
    driveAccess(32'h102, 32'h0, 3'b010, 1'b0);
    #1;
    checkOutput("mis_flag", mem_misaligned, 1);
    checkOutput("mis_req", dbus_req, 0);
    checkOutput("mis_stall", mem_stall, 0);
    checkOutput("mis_load", mem_load_data, 0);
    @(negedge clk);
    idleInputs();
`endif

    checkOutput("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access (MEM) stage load/store unit of the RV32I 5-stage pipeline.
- Sits directly downstream of the EX/MEM pipeline register and consumes its address, store data and MemRead/MemWrite controls.
- Drives a req/gnt/rvalid data-bus master port.
- Formats load data (byte/half/word, sign/zero extend) for the MEM/WB register.
- Raises a stall to the hazard unit while a bus transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data width; fixed at 32 for RV32I, other values unsupported.
- ADDR_WIDTH, 32, byte address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_alu_result  in  ADDR_WIDTH  byte address from EX/MEM
- mem_rs2_data  in  DATA_WIDTH  store data from EX/MEM
- mem_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_MemRead  in  1  load in MEM stage
- mem_MemWrite  in  1  store in MEM stage
- mem_flush  in  1  discard current MEM instruction
- wb_ready  in  1  MEM/WB register enable this cycle
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  DATA_WIDTH  lane-replicated store data
- dbus_be  out  BE_WIDTH  byte enables
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response valid (read data or write ack)
- dbus_rdata  in  DATA_WIDTH  read data
- mem_load_data  out  DATA_WIDTH  formatted load result to MEM/WB
- mem_stall  out  1  hold IF..EX/MEM
- mem_misaligned  out  1  misaligned access flag

Behaviour:
- access = MemRead | MemWrite. Both set simultaneously is illegal; treat as load.
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE. Reset values: load_data_q=0, discard=0. All outputs are 0 in IDLE with no access.
- IDLE:
  - With an access, dbus_req=1 combinationally.
  - gnt in the same cycle -> RESP; otherwise -> REQ.
- REQ:
  - dbus_req=1; addr, we, be and wdata held stable (the stall freezes EX/MEM).
  - gnt -> RESP.
- RESP:
  - On rvalid, formatted rdata is driven to mem_load_data that same cycle and captured into load_data_q.
  - wb_ready=1 -> IDLE; wb_ready=0 -> DONE.
- DONE:
  - mem_load_data = load_data_q and no request is issued, so there is no re-issue while the pipeline is held externally.
  - wb_ready -> IDLE.
- mem_stall = access & ~(RESP & rvalid) & ~DONE.
- Minimum latency: gnt in cycle 0, rvalid in cycle 1, i.e. 1 stall cycle. rvalid is never earlier than the cycle after gnt.
- Store byte enables and data:
  - SB: be=0001<<a[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<a[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
  - Loads: be=1111.
- Load formatting:
  - Select the byte/half lane by a[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Flush:
  - Flush in IDLE or DONE: clear to IDLE and issue no request.
  - Flush in REQ or RESP: the transaction runs to rvalid because a request is never withdrawn before gnt. Set discard=1. On completion mem_load_data=0, then go to IDLE.
  - A store already granted is committed.
- Reset mid-transaction returns to IDLE immediately. The bus is expected to be reset together with this block.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - mem_misaligned=1 combinationally for H with a[0]=1, or W with a[1:0]!=0.
  - No bus request is issued, no stall, mem_load_data=0.
- Undefined:
  - mem_misaligned tied to 0.
  - Misaligned H/W use lanes from a[1:0] truncated to size alignment (H: a[1]; W: lane 0).

Decomposition:
- Package lsu_pkg:
  - lsu_state_e enum (IDLE, REQ, RESP, DONE).
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-module lsu_align (combinational): store be/wdata generation and load extract/extend.
- FSM and stall logic stay in mem_stage_lsu.

Test Plan:
- LW at 0x100, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF -> req one cycle, stall one cycle, mem_load_data=0xDEADBEEF on the rvalid cycle.
- LB at 0x103, rdata=0x80FF_0000 -> mem_load_data=0xFFFFFF80; LBU -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SB at 0x101 with rs2=0x000000AB, gnt delayed 3 cycles -> req, addr=0x100, be=0010, wdata=0xABABABAB stable for 4 cycles; stall until the ack.
- Load completes with wb_ready=0 for 2 cycles -> DONE, no second req, mem_load_data held, IDLE after wb_ready.
- Flush in REQ, gnt then rvalid follow -> one bus transaction only, mem_load_data=0, back to IDLE.
- With LSU_MISALIGN_CHECK_EN, LW at 0x102 -> mem_misaligned=1, dbus_req=0, mem_stall=0.
